// File: rtl/uart_pattern_pkg.sv
// Shared constants and state encodings for the UART pattern loader.
package uart_pattern_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM
    } frame_state_e;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, start validation, mid-bit sampling.
module uart_rx_byte
    import uart_pattern_pkg::*;
#(
    parameter int DIV = 217
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    // [1] is the synchronised line, [2] its previous value
    logic [2:0]    sync_q, sync_d;
    uart_state_e   state_q, state_d;
    logic          hunt_q, hunt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    logic rx_s;
    logic rx_fall;

    assign rx_s    = sync_q[1];
    // Edge-triggered start: a line held low after a bad stop bit is not a new start
    assign rx_fall = sync_q[2] & ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[1:0], rxd};
        state_d = state_q;
        hunt_d  = hunt_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!hunt_q) begin
                    if (rx_fall) begin
                        hunt_d = 1'b1;
                        cnt_d  = '0;
                    end
                end else if (cnt_q == HALF_M1) begin
                    hunt_d = 1'b0;
                    cnt_d  = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 3'b111;
            state_q <= IDLE;
            hunt_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            hunt_q  <= hunt_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;

endmodule

// File: rtl/uart_pattern_loader.sv
// Parses A5/LEN/data/CHK frames from the UART and writes the pattern memory.
module uart_pattern_loader
    import uart_pattern_pkg::*;
#(
    parameter int CLK_FREQ     = 25000000,
    parameter int BAUD         = 115200,
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 21,
    parameter int ADDR_W       = 5,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [ADDR_W-1:0] pat_last,
    output logic              pat_valid,
    output logic              loading,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TMO = TIMEOUT_BITS * DIV;
    localparam int TW  = $clog2(TMO + 1);

    logic [7:0] rx_byte;
    logic       rx_ok;
    logic       rx_ferr;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk   (clk),
        .resetn(resetn),
        .rxd   (rxd),
        .data  (rx_byte),
        .valid (rx_ok),
        .ferr  (rx_ferr)
    );

    frame_state_e      fst_q, fst_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic              wrote_q, wrote_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              pv_q, pv_d;
    logic              load_q, load_d;
    logic              err_q, err_d;

    logic in_frame;
    logic bad;

    assign in_frame = (fst_q != WAIT_SYNC);

    always_comb begin
        fst_d   = fst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wrote_d = wrote_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        pv_d    = pv_q;
        load_d  = load_q;
        bad     = 1'b0;
        tmo_d   = (in_frame && !rx_ok) ? tmo_q + 1'b1 : '0;
        unique case (fst_q)
            WAIT_SYNC: begin
                if (rx_ok && rx_byte == SYNC_BYTE) begin
                    fst_d   = GET_LEN;
                    load_d  = 1'b1;
                    wrote_d = 1'b0;
                end
            end
            GET_LEN: begin
                if (rx_ok) begin
                    if (rx_byte != 8'd0 && rx_byte <= 8'(DEPTH)) begin
                        len_d = rx_byte;
                        cnt_d = '0;
                        acc_d = '0;
                        fst_d = GET_DATA;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            GET_DATA: begin
                if (rx_ok) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = rx_byte[WIDTH-1:0];
                    acc_d   = acc_q ^ rx_byte;
                    cnt_d   = cnt_q + 8'd1;
                    wrote_d = 1'b1;
                    if (cnt_q + 8'd1 == len_q) fst_d = GET_SUM;
                end
            end
            GET_SUM: begin
                if (rx_ok) begin
                    if (rx_byte == acc_q) begin
                        last_d = ADDR_W'(len_q - 8'd1);
                        pv_d   = 1'b1;
                        load_d = 1'b0;
                        fst_d  = WAIT_SYNC;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            default: fst_d = WAIT_SYNC;
        endcase
        if (in_frame && (rx_ferr || (!rx_ok && tmo_q == TW'(TMO - 1)))) begin
            bad = 1'b1;
        end
        // A UART error inside a frame folds into the frame abort: one pulse only
        err_d = bad || rx_ferr;
        if (bad) begin
            fst_d  = WAIT_SYNC;
            load_d = 1'b0;
            tmo_d  = '0;
            if (wrote_q) pv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fst_q   <= WAIT_SYNC;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            wrote_q <= 1'b0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= ADDR_W'(DEPTH - 1);
            pv_q    <= 1'b1;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fst_q   <= fst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wrote_q <= wrote_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            pv_q    <= pv_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pat_last  = last_q;
    assign pat_valid = pv_q;
    assign loading   = load_q;
    assign rx_data   = rx_byte;
    assign rx_valid  = rx_ok;
    assign frame_err = err_q;

endmodule

// File: doc/uart_pattern_loader.md
Name: uart_pattern_loader

Overview:
Loads the LED animation pattern memory from the host over the FTDI UART link (ftdi_rxd). It deserialises 8N1 bytes, parses a framed packet, and drives a write port into the pattern BRAM that the LED player reads. It also publishes the index of the last valid pattern step, which the player uses as its wrap point.

Parameters:
CLK_FREQ, 25000000, input clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_FREQ/BAUD (integer division, 217 at defaults)
WIDTH, 8, pattern word width; must be <= 8; stored word = received byte[WIDTH-1:0]
DEPTH, 21, number of pattern memory entries
ADDR_W, 5, address width; requires 2^ADDR_W >= DEPTH
TIMEOUT_BITS, 20, maximum idle gap between bytes inside a frame, in bit times

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rxd  in  1  UART serial input, idle high, asynchronous to clk
mem_we  out  1  one-cycle write strobe to the pattern memory
mem_addr  out  ADDR_W  write address
mem_wdata  out  WIDTH  write data
pat_last  out  ADDR_W  index of the last valid pattern step
pat_valid  out  1  pattern memory holds a complete, checked pattern
loading  out  1  high while a frame is in progress; the player must hold its position
rx_data  out  8  last received byte (debug)
rx_valid  out  1  one-cycle pulse per received byte (debug)
frame_err  out  1  one-cycle pulse on any protocol or UART error

Behaviour:
- Reset (asynchronous, resetn=0). All strobes are 0, rx_data=0, loading=0, FSM=WAIT_SYNC, UART=IDLE. pat_last=DEPTH-1 and pat_valid=1, so the power-up pattern plays.
- Input synchronisation. rxd passes through a 2-FF synchroniser; the synchronisers reset to 1.
- UART receiver:
  - IDLE: a synchronised 0 starts a count of DIV/2. If the line is still 0 at the half-bit point, enter DATA. If it has returned to 1, treat it as a glitch and return to IDLE with no error.
  - DATA: sample 8 bits every DIV clocks, LSB first.
  - STOP: sample after DIV clocks. A 1 pulses rx_valid and updates rx_data in the same cycle. A 0 is a framing error: pulse frame_err, return to IDLE, no rx_valid.
- Frame format: 0xA5, LEN, LEN data bytes, CHK. CHK is the XOR of all data bytes (the full 8 bits).
- Frame FSM (advances only on rx_valid):
  - WAIT_SYNC: 0xA5 moves to GET_LEN and sets loading=1. Any other byte is ignored silently.
  - GET_LEN: LEN in 1..DEPTH sets cnt=0, acc=0 and moves to GET_DATA. LEN=0 or LEN>DEPTH is an error.
  - GET_DATA: each byte produces mem_we=1 in the following cycle, with mem_addr=cnt and mem_wdata=byte[WIDTH-1:0]. The byte is XORed into acc and cnt increments. When cnt reaches LEN, move to GET_SUM.
  - GET_SUM: CHK==acc → pat_last=LEN-1, pat_valid=1, loading=0, back to WAIT_SYNC. Mismatch is an error.
  - Error, any state: pulse frame_err, pat_valid=0 if any data byte was written in this frame, loading=0, back to WAIT_SYNC. pat_last is unchanged.
- Inter-byte timeout. In GET_LEN, GET_DATA or GET_SUM, a gap of TIMEOUT_BITS*DIV clocks with no rx_valid is an error. The timer restarts on each rx_valid.
- UART errors inside a frame. A framing error while the frame FSM is in GET_LEN, GET_DATA or GET_SUM also aborts the frame as an error. This produces a single frame_err pulse, not two.
- pat_valid stays 0 after an aborted write until the next good frame completes.
- mem_we is never asserted outside GET_DATA, and mem_addr never exceeds LEN-1.
- Reset mid-frame or mid-byte: immediate return to reset values. Memory contents are undefined, but pat_valid=1 because pat_last=DEPTH-1.

Decomposition:
- Package uart_pattern_pkg: SYNC_BYTE=8'hA5; frame state enum (WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM); UART state enum (IDLE, DATA, STOP).
- Sub-module uart_rx_byte: synchroniser, bit timing, 8N1 deserialiser. Outputs: data[7:0], valid, ferr. Parameter: DIV.
- The framing FSM, checksum accumulator, timeout counter and write port live in uart_pattern_loader.

Test Plan:
1. Frame A5 03 07 02 05 00 (00 = 07^02^05) → three mem_we pulses at addr 0,1,2 with data 07,02,05; then pat_last=2, pat_valid=1, loading returns to 0; no frame_err.
2. Same frame with CHK=FF → 3 writes, then one frame_err pulse; pat_valid=0; pat_last keeps its prior value (20 after reset). A following good frame restores pat_valid=1.
3. Frame A5 00, and separately A5 16 (LEN=22 > 21) → frame_err, no mem_we, pat_valid stays 1.
4. Byte with stop bit driven 0 while in WAIT_SYNC → frame_err, no rx_valid. A 0.3-bit low glitch on rxd → no rx_valid, no error.
5. A5 02 11, then silence for 21 bit times → frame_err at 20 bit times after the 0x11 stop sample; one write at addr 0; pat_valid=0.
6. Assert resetn=0 mid-way through the data byte of A5 02 … → all outputs at reset values (pat_last=20, pat_valid=1, loading=0). Leading bytes 00 3C before a good frame → ignored, and the good frame is accepted.
